// File: rtl/found_capture.sv
// found_capture
//
// Sits behind the 16-lane MD5 pipeline array. It rebuilds the 32-bit candidate that
// produced a hit by delaying the shared counter through a LATENCY-deep shift register.
// It then latches {delayed counter, lane index} and holds the result until clear_i.
//
// Ports:
//   clk_i          system clock, all state on the rising edge
//   rst_ni         asynchronous active-low reset
//   clear_i        synchronous re-arm pulse; discards a held result (ignored in warm-up)
//   counter_i      counter value presented to all lanes this cycle
//   found_vec_i    bit i = lane i match strobe
//   armed_o        capture window open
//   match_valid_o  result held; drives the found LED/pin and the counter halt
//   match_value_o  {delayed counter, lane index} of the captured hit
//   match_lane_o   lane index of the captured hit
//   multi_hit_o    more than one hit seen since capture (same cycle or later)
//   hit_count_o    cycles with any hit since capture, saturating at 255
module found_capture #(
    parameter int unsigned LANES     = 16,
    parameter int unsigned LANE_BITS = 4,
    parameter int unsigned COUNT_W   = 28,
    parameter int unsigned LATENCY   = 66
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic [COUNT_W-1:0]           counter_i,
    input  logic [LANES-1:0]             found_vec_i,
    output logic                         armed_o,
    output logic                         match_valid_o,
    output logic [COUNT_W+LANE_BITS-1:0] match_value_o,
    output logic [LANE_BITS-1:0]         match_lane_o,
    output logic                         multi_hit_o,
    output logic [7:0]                   hit_count_o
);

    localparam int unsigned FillW = $clog2(LATENCY + 1);
    localparam logic [FillW-1:0] FillMax  = FillW'(LATENCY);
    localparam logic [FillW-1:0] FillLast = FillW'(LATENCY - 1);

    typedef enum logic [1:0] {
        StWarmup,
        StArmed,
        StHeld
    } state_e;

    state_e                         state_q;
    logic [COUNT_W-1:0]             dly_q [LATENCY];
    logic [FillW-1:0]               fill_q;
    logic                           armed_q;
    logic                           valid_q;
    logic [COUNT_W+LANE_BITS-1:0]   value_q;
    logic [LANE_BITS-1:0]           lane_q;
    logic                           multi_q;
    logic [7:0]                     count_q;

    logic                           any_hit;
    logic                           many_hits;
    logic [LANE_BITS-1:0]           enc_lane;

    // Shifts in every state, including HELD, so the tap is always aligned with the
    // pipeline output. Counter wrap and stalls need no special handling.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            dly_q[0] <= counter_i;
            for (int i = 1; i < int'(LATENCY); i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    // Counts how many stages hold real samples; saturates once the tap is valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fill_q <= '0;
        end else if (fill_q != FillMax) begin
            fill_q <= fill_q + FillW'(1);
        end
    end

    // Lowest-index lane wins.
    always_comb begin
        enc_lane = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (found_vec_i[i]) begin
                enc_lane = LANE_BITS'(i);
            end
        end
    end

    assign any_hit   = |found_vec_i;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign many_hits = |(found_vec_i & (found_vec_i - LANES'(1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StWarmup;
            armed_q <= 1'b0;
            valid_q <= 1'b0;
            value_q <= '0;
            lane_q  <= '0;
            multi_q <= 1'b0;
            count_q <= '0;
        end else begin
            unique case (state_q)
                // Pipeline contents are stale until the delay line is full.
                StWarmup: begin
                    if (fill_q == FillLast) begin
                        state_q <= StArmed;
                        armed_q <= 1'b1;
                    end
                end
                StArmed: begin
                    if (clear_i) begin
                        // Clear beats a same-cycle hit.
                        armed_q <= 1'b1;
                        valid_q <= 1'b0;
                        value_q <= '0;
                        lane_q  <= '0;
                        multi_q <= 1'b0;
                        count_q <= '0;
                    end else if (any_hit) begin
                        state_q <= StHeld;
                        armed_q <= 1'b0;
                        valid_q <= 1'b1;
                        value_q <= {dly_q[LATENCY-1], enc_lane};
                        lane_q  <= enc_lane;
                        multi_q <= many_hits;
                        count_q <= 8'd1;
                    end
                end
                StHeld: begin
                    if (clear_i) begin
                        state_q <= StArmed;
                        armed_q <= 1'b1;
                        valid_q <= 1'b0;
                        value_q <= '0;
                        lane_q  <= '0;
                        multi_q <= 1'b0;
                        count_q <= '0;
                    end else if (any_hit) begin
                        multi_q <= 1'b1;
                        if (count_q != 8'hFF) begin
                            count_q <= count_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= StWarmup;
                    armed_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign armed_o       = armed_q;
    assign match_valid_o = valid_q;
    assign match_value_o = value_q;
    assign match_lane_o  = lane_q;
    assign multi_hit_o   = multi_q;
    assign hit_count_o   = count_q;

endmodule

// File: doc/found_capture.md
Name: found_capture

Overview:
- Sits directly downstream of the 16-lane MD5 pipeline array.
- Consumes the 16 per-lane found strobes and the shared 28-bit candidate counter.
- Reconstructs the exact 32-bit candidate that produced the hit by delaying the counter value by the pipeline latency, then latches it with the lane index.
- Holds the result for the display, the found LED/pin and the counter-halt logic until it is cleared.

Parameters:
LANES, 16, number of pipeline lanes (found_vec width)
LANE_BITS, 4, log2(LANES); low bits appended to counter
COUNT_W, 28, width of shared counter value
LATENCY, 66, clock cycles from pipeline counter_in sample to its found output

Ports:
CLK  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous re-arm pulse (debounced), discards held result
counter_in  input  COUNT_W  counter value presented to all lanes this cycle
found_vec  input  LANES  bit i = lane i match strobe
armed  output  1  1 in ARMED state (capture window open)
match_valid  output  1  1 in HELD state; drives found LED/pin and counter halt
match_value  output  COUNT_W+LANE_BITS  {delayed counter, lane index} of the captured hit
match_lane  output  LANE_BITS  lane index of the captured hit
multi_hit  output  1  more than one hit seen since capture (same cycle or later)
hit_count  output  8  number of found_vec!=0 cycles since capture, saturating at 255

Behaviour:
- Delay line
  - Shift register, LATENCY stages × COUNT_W bits.
  - Shifts counter_in every cycle in every state, including HELD.
  - Output tap = counter_in sampled exactly LATENCY cycles earlier.
- Fill counter
  - Counts 0..LATENCY after reset, then saturates.
  - Delay tap is valid only once fill == LATENCY.
- States: WARMUP, ARMED, HELD.
  - Reset → WARMUP.
  - WARMUP → ARMED on the edge where fill reaches LATENCY.
  - found_vec is ignored in WARMUP because pipeline contents are stale.
- ARMED, on an edge with found_vec != 0:
  - match_lane = index of the lowest set bit.
  - match_value = {delay tap, match_lane}.
  - hit_count = 1.
  - multi_hit = 1 if more than one bit is set, else 0.
  - Next state HELD.
  - Registered: match_valid is high in the cycle after found is sampled.
- HELD
  - match_value and match_lane are frozen.
  - Each cycle with found_vec != 0: hit_count += 1 (saturates at 255) and multi_hit is set.
  - Remains in HELD until clear.
- clear (synchronous)
  - From HELD or ARMED: outputs return to reset values, next state ARMED, fill not restarted.
  - clear and found_vec != 0 in the same cycle: clear wins, hit discarded.
  - clear in WARMUP: no effect.
- Reset values: armed=0, match_valid=0, match_value=0, match_lane=0, multi_hit=0, hit_count=0, fill=0, delay line=0.
  - Reset asserted mid-operation clears everything immediately (asynchronous).
  - Deassertion restarts WARMUP.
- Arithmetic: no subtraction on counter values; recovery is purely by the delay line, so counter wrap-around and counter stalls (step/enable low) are handled implicitly.
- Priority encoder: the lowest index wins.

Test Plan:
- Warm-up gating: reset, hold found_vec=16'h0001 for cycles 0..65 → armed=0 and match_valid=0 throughout; armed=1 from cycle 66.
- Basic capture:
  - Stimulus: counter_in = cycle number; found_vec=16'h0020 single pulse at cycle 100.
  - Required: match_valid=1 from cycle 101, match_lane=5, match_value={28'd34,4'h5}=32'h225, hit_count=1, multi_hit=0.
- Simultaneous lanes: ARMED, found_vec=16'h8104 at cycle 120 with tap=28'h0ABCDEF → match_lane=2, match_value=32'h0ABCDEF2, multi_hit=1.
- HELD accumulation:
  - Stimulus: after a capture, 300 further cycles with found_vec=16'h0001.
  - Required: match_value unchanged, hit_count saturates at 255, multi_hit=1.
- Clear collision:
  - Stimulus: HELD, clear=1 and found_vec=16'h0010 in the same cycle.
  - Required: next cycle armed=1, match_valid=0, hit_count=0. A following found_vec=16'h0010 captures match_lane=4.
- Reset mid-HELD: drive reset=0 asynchronously between edges → all outputs 0 immediately; after release, armed stays 0 for 66 cycles.
